// File: rtl/mc_pkg.sv
// Shared types and decode constants for the multicycle MIPS control unit.
// MC_ORI_EN adds the ORI opcode and its two states.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
`ifdef MC_ORI_EN
        S_JEX     = 4'd12,
        S_ORIEX   = 4'd13,
        S_ORIWB   = 4'd14
`else
        S_JEX     = 4'd12
`endif
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic op_known(input logic [5:0] op);
        logic known;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: known = 1'b1;
`ifdef MC_ORI_EN
            OP_ORI: known = 1'b1;
`endif
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// R-type funct decoder: ALU operation plus a flag for recognised funct codes.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucont,
    output logic       funct_ok
);

    always_comb begin
        alucont  = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alucont = ALU_ADD;
            FN_SUB:  alucont = ALU_SUB;
            FN_AND:  alucont = ALU_AND;
            FN_OR:   alucont = ALU_OR;
            FN_SLT:  alucont = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory handshake and bounded-wait timeout.
// Optional ORI support is compiled in with MC_ORI_EN.
//
// state   | meaning
// IDLE    | post-reset, all controls off
// FETCH   | read instruction at PC, PC+4
// DECODE  | decode op, precompute branch target
// MEMADR  | compute lw/sw address
// MEMRD   | load data read
// MEMWB   | load write-back
// MEMWR   | store write
// RTYPEEX | R-type execute
// RTYPEWB | R-type write-back
// BEQEX   | branch compare / PC update
// ADDIEX  | addi execute
// ADDIWB  | addi write-back
// JEX     | jump
// ORIEX   | ori execute (MC_ORI_EN)
// ORIWB   | ori write-back (MC_ORI_EN)
module mc_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pc_en,
    output logic [2:0] alucont,
    output logic       immzext,
    output logic       illegal,
    output logic       bus_err
);

    state_e     state, state_nxt;
    logic [7:0] tmo_cnt;
    logic       bus_err_q;
    logic       wait_cyc, tmo;
    logic [2:0] rt_alucont;
    logic       funct_ok;

    mc_aludec u_aludec (
        .funct   (funct),
        .alucont (rt_alucont),
        .funct_ok(funct_ok)
    );

    // Down-counter reloads on every non-wait cycle; terminal count ends the access.
    assign wait_cyc = (state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && !mem_ready;
    assign tmo      = wait_cyc && (tmo_cnt == 8'd1);
    assign bus_err  = bus_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            tmo_cnt   <= 8'(TIMEOUT);
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_err_q <= tmo;
            if (wait_cyc && !tmo) tmo_cnt <= tmo_cnt - 8'd1;
            else                  tmo_cnt <= 8'(TIMEOUT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JEX;
`ifdef MC_ORI_EN
                    OP_ORI:       state_nxt = S_ORIEX;
`endif
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:  state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) state_nxt = S_MEMWB;
                else if (tmo)  state_nxt = S_FETCH;
            end
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   if (mem_ready || tmo) state_nxt = S_FETCH;
            S_RTYPEEX: state_nxt = funct_ok ? S_RTYPEWB : S_FETCH;
            S_RTYPEWB: state_nxt = S_FETCH;
            S_BEQEX:   state_nxt = S_FETCH;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            S_ADDIWB:  state_nxt = S_FETCH;
            S_JEX:     state_nxt = S_FETCH;
`ifdef MC_ORI_EN
            S_ORIEX:   state_nxt = S_ORIWB;
            S_ORIWB:   state_nxt = S_FETCH;
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pc_en    = 1'b0;
        alucont  = ALU_ADD;
        immzext  = 1'b0;
        illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pc_en   = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = !op_known(op);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                alucont = rt_alucont;
                illegal = !funct_ok;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                alucont = ALU_SUB;
                pcsrc   = 2'b01;
                pc_en   = zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc = 2'b10;
                pc_en = 1'b1;
            end
`ifdef MC_ORI_EN
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alucont = ALU_OR;
                immzext = 1'b1;
            end
            S_ORIWB: begin
                regwrite = 1'b1;
                immzext  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expectations queued with their stimulus.
// Honours MC_ORI_EN the same way the design does.
module tb_mc_controller;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, ORI = 6'b001101, BAD = 6'b111111;

    typedef struct packed {
        logic       mem_req, memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       pc_en;
        logic [2:0] alucont;
        logic       immzext, illegal, bus_err;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op, funct;
        logic       rdy, z;
        ctl_t       exp;
    } ent_t;

    typedef enum int {
        B_IDLE, B_FETCH, B_DECODE, B_MEMADR, B_MEMRD, B_MEMWB, B_MEMWR, B_RTYPEEX,
        B_RTYPEWB, B_BEQEX, B_ADDIEX, B_ADDIWB, B_JEX, B_ORIEX, B_ORIWB
    } bst_e;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pc_en, immzext, illegal, bus_err;
    logic [2:0] alucont;
    ctl_t       obs;

    ent_t  sb[$];
    string tags[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    mc_controller #(.TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite),
        .iord(iord), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pc_en(pc_en),
        .alucont(alucont), .immzext(immzext), .illegal(illegal), .bus_err(bus_err)
    );

    always_comb obs = {mem_req, memwrite, irwrite, iord, regwrite, regdst, memtoreg, alusrca,
                       alusrcb, pcsrc, pc_en, alucont, immzext, illegal, bus_err};

    function automatic ctl_t model(input bst_e s, input logic rdy, input logic z);
        ctl_t c;
        c = '0;
        c.alucont = 3'b010;
        case (s)
            B_FETCH:   begin c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pc_en = rdy; end
            B_DECODE:  c.alusrcb = 2'b11;
            B_MEMADR:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            B_MEMRD:   begin c.mem_req = 1; c.iord = 1; end
            B_MEMWB:   begin c.regwrite = 1; c.memtoreg = 1; end
            B_MEMWR:   begin c.mem_req = 1; c.memwrite = 1; c.iord = 1; end
            B_RTYPEEX: c.alusrca = 1;
            B_RTYPEWB: begin c.regwrite = 1; c.regdst = 1; end
            B_BEQEX:   begin c.alusrca = 1; c.alucont = 3'b110; c.pcsrc = 2'b01; c.pc_en = z; end
            B_ADDIEX:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            B_ADDIWB:  c.regwrite = 1;
            B_JEX:     begin c.pcsrc = 2'b10; c.pc_en = 1; end
            B_ORIEX:   begin c.alusrca = 1; c.alusrcb = 2'b10; c.alucont = 3'b001; c.immzext = 1; end
            B_ORIWB:   begin c.regwrite = 1; c.immzext = 1; end
            default:   ;
        endcase
        return c;
    endfunction

    task automatic q(input string tag, input bst_e s, input logic [5:0] o, input logic [5:0] f,
                     input logic rdy, input logic z, input logic ill = 1'b0,
                     input logic berr = 1'b0, input int alu = -1);
        ent_t e;
        e.op = o; e.funct = f; e.rdy = rdy; e.z = z;
        e.exp = model(s, rdy, z);
        e.exp.illegal = ill;
        e.exp.bus_err = berr;
        if (alu >= 0) e.exp.alucont = 3'(alu);
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    task automatic check(input string tag, input ctl_t exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; drives each entry, compares on the falling edge.
    task automatic drain();
        ent_t  e;
        string t;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            t = tags.pop_front();
            op = e.op; funct = e.funct; mem_ready = e.rdy; zero = e.z;
            @(negedge clk);
            check(t, e.exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        check("reset_idle", model(B_IDLE, 0, 0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        q("lw_idle", B_IDLE, LW, 0, 1, 0);
        q("lw_fetch", B_FETCH, LW, 0, 1, 0);
        q("lw_decode", B_DECODE, LW, 0, 1, 0);
        q("lw_memadr", B_MEMADR, LW, 0, 1, 0);
        q("lw_memrd", B_MEMRD, LW, 0, 1, 0);
        q("lw_memwb", B_MEMWB, LW, 0, 1, 0);

        q("sw_fetch", B_FETCH, SW, 0, 1, 0);
        q("sw_decode", B_DECODE, SW, 0, 1, 0);
        q("sw_memadr", B_MEMADR, SW, 0, 1, 0);
        for (int i = 0; i < 3; i++) q("sw_memwr_wait", B_MEMWR, SW, 0, 0, 0);
        q("sw_memwr_done", B_MEMWR, SW, 0, 1, 0);

        q("slt_fetch", B_FETCH, RT, 6'b101010, 1, 0);
        q("slt_decode", B_DECODE, RT, 6'b101010, 0, 0);
        q("slt_ex", B_RTYPEEX, RT, 6'b101010, 0, 0, 0, 0, 7);
        q("slt_wb", B_RTYPEWB, RT, 6'b101010, 0, 0);

        q("or_fetch", B_FETCH, RT, 6'b100101, 1, 0);
        q("or_decode", B_DECODE, RT, 6'b100101, 0, 0);
        q("or_ex", B_RTYPEEX, RT, 6'b100101, 0, 0, 0, 0, 1);
        q("or_wb", B_RTYPEWB, RT, 6'b100101, 0, 0);

        q("badfn_fetch", B_FETCH, RT, 6'b000111, 1, 0);
        q("badfn_decode", B_DECODE, RT, 6'b000111, 0, 0);
        q("badfn_ex", B_RTYPEEX, RT, 6'b000111, 0, 0, 1);

        q("beq1_fetch", B_FETCH, BEQ, 0, 1, 0);
        q("beq1_decode", B_DECODE, BEQ, 0, 0, 1);
        q("beq1_ex", B_BEQEX, BEQ, 0, 0, 1);
        q("beq0_fetch", B_FETCH, BEQ, 0, 1, 0);
        q("beq0_decode", B_DECODE, BEQ, 0, 0, 0);
        q("beq0_ex", B_BEQEX, BEQ, 0, 0, 0);

        q("addi_fetch", B_FETCH, ADDI, 0, 1, 0);
        q("addi_decode", B_DECODE, ADDI, 0, 0, 0);
        q("addi_ex", B_ADDIEX, ADDI, 0, 0, 0);
        q("addi_wb", B_ADDIWB, ADDI, 0, 0, 0);

        q("j_fetch", B_FETCH, JMP, 0, 1, 0);
        q("j_decode", B_DECODE, JMP, 0, 0, 0);
        q("j_ex", B_JEX, JMP, 0, 0, 0);

        q("badop_fetch", B_FETCH, BAD, 0, 1, 0);
        q("badop_decode", B_DECODE, BAD, 0, 0, 0, 1);

        for (int i = 0; i < 15; i++) q("ftmo_wait", B_FETCH, JMP, 0, 0, 0);
        q("ftmo_buserr", B_FETCH, JMP, 0, 0, 0, 0, 1);
        q("ftmo_retry", B_FETCH, JMP, 0, 1, 0);
        q("ftmo_decode", B_DECODE, JMP, 0, 0, 0);
        q("ftmo_jex", B_JEX, JMP, 0, 0, 0);

        q("lwtmo_fetch", B_FETCH, LW, 0, 1, 0);
        q("lwtmo_decode", B_DECODE, LW, 0, 0, 0);
        q("lwtmo_memadr", B_MEMADR, LW, 0, 0, 0);
        for (int i = 0; i < 15; i++) q("lwtmo_wait", B_MEMRD, LW, 0, 0, 0);
        q("lwtmo_abort", B_FETCH, ADDI, 0, 1, 0, 0, 1);
        q("lwtmo_next_decode", B_DECODE, ADDI, 0, 0, 0);
        q("lwtmo_next_ex", B_ADDIEX, ADDI, 0, 0, 0);
        q("lwtmo_next_wb", B_ADDIWB, ADDI, 0, 0, 0);

        q("rst_fetch", B_FETCH, LW, 0, 1, 0);
        q("rst_decode", B_DECODE, LW, 0, 0, 0);
        q("rst_memadr", B_MEMADR, LW, 0, 0, 0);
        q("rst_memrd", B_MEMRD, LW, 0, 0, 0);
        drain();

        mem_ready = 1'b0;
        #1;
        check("pre_reset_memrd", model(B_MEMRD, 0, 0));
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_async", model(B_IDLE, 0, 0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        q("ori_idle", B_IDLE, ORI, 0, 0, 0);
        q("ori_fetch", B_FETCH, ORI, 0, 1, 0);
`ifdef MC_ORI_EN
        q("ori_decode", B_DECODE, ORI, 0, 0, 0);
        q("ori_ex", B_ORIEX, ORI, 0, 0, 0);
        q("ori_wb", B_ORIWB, ORI, 0, 0, 0);
`else
        q("ori_decode_illegal", B_DECODE, ORI, 0, 0, 0, 1);
`endif
        q("ori_after_fetch", B_FETCH, ORI, 0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
